// File: rtl/gpio_in_debounce_if.sv
// Board-input conditioning bus: raw button inputs in, debounced level plus
// rise/fall strobes and per-channel busy flags out.
interface gpio_in_debounce_if #(
  parameter int IO_NUM = 2
);
  logic [IO_NUM-1:0] BTN_IN;
  logic [IO_NUM-1:0] GPIO_IN;
  logic [IO_NUM-1:0] RISE;
  logic [IO_NUM-1:0] FALL;
  logic [IO_NUM-1:0] BUSY;

  modport master (output BTN_IN, input GPIO_IN, RISE, FALL, BUSY);
  modport slave  (input BTN_IN, output GPIO_IN, RISE, FALL, BUSY);
endinterface

// File: rtl/gpio_in_debounce.sv
// Per-channel synchroniser plus counter-based debounce filter feeding the
// CoreGPIO GPIO_IN pins, with one-cycle rise/fall strobes.
module gpio_in_debounce #(
  parameter int               IO_NUM          = 2,
  parameter int               SYNC_STAGES     = 2,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter logic [IO_NUM-1:0] RESET_VAL      = '0
) (
  input logic               PCLK,
  input logic               PRESETN,
  gpio_in_debounce_if.slave bus
);

  localparam int DEB_EFF = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(DEB_EFF + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_EFF);

  typedef enum logic {ST_STABLE, ST_COUNT} state_e;

  logic [IO_NUM-1:0] sync_q [SYNC_STAGES];
  logic [IO_NUM-1:0] s_sync;
  state_e            state_q [IO_NUM];
  logic [CW-1:0]     cnt_q   [IO_NUM];
  logic [IO_NUM-1:0] gpio_q;
  logic [IO_NUM-1:0] rise_q;
  logic [IO_NUM-1:0] fall_q;
  logic [IO_NUM-1:0] busy_q;

  assign s_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      // NOTE: the sync chain and per-channel arrays are plain flops, not RAM,
      // so every element is reset explicitly in a loop.
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= RESET_VAL;
      for (int ch = 0; ch < IO_NUM; ch++) begin
        state_q[ch] <= ST_STABLE;
        cnt_q[ch]   <= '0;
      end
      gpio_q <= RESET_VAL;
      rise_q <= '0;
      fall_q <= '0;
      busy_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let each chain flop sample the
      // previous stage's old value, giving a true shift register.
      sync_q[0] <= bus.BTN_IN;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];

      rise_q <= '0;
      fall_q <= '0;

      for (int ch = 0; ch < IO_NUM; ch++) begin
        case (state_q[ch])
          ST_STABLE: begin
            if (s_sync[ch] != gpio_q[ch]) begin
              state_q[ch] <= ST_COUNT;
              cnt_q[ch]   <= CW'(1);
              busy_q[ch]  <= 1'b1;
            end else begin
              cnt_q[ch] <= '0;
            end
          end
          ST_COUNT: begin
            if (s_sync[ch] == gpio_q[ch]) begin
              // Bounced back before qualifying: drop the pending change.
              state_q[ch] <= ST_STABLE;
              cnt_q[ch]   <= '0;
              busy_q[ch]  <= 1'b0;
            end else if (cnt_q[ch] == DEB_MAX) begin
              gpio_q[ch]  <= s_sync[ch];
              rise_q[ch]  <= s_sync[ch];
              fall_q[ch]  <= ~s_sync[ch];
              state_q[ch] <= ST_STABLE;
              cnt_q[ch]   <= '0;
              busy_q[ch]  <= 1'b0;
            end else begin
              cnt_q[ch] <= cnt_q[ch] + 1'b1;
            end
          end
          default: begin
            state_q[ch] <= ST_STABLE;
            cnt_q[ch]   <= '0;
            busy_q[ch]  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.GPIO_IN = gpio_q;
  assign bus.RISE    = rise_q;
  assign bus.FALL    = fall_q;
  assign bus.BUSY    = busy_q;

endmodule
